// File: rtl/cmd_sequencer.sv
// cmd_sequencer: frames a command byte stream into CTRL / CLRSTAT / WRITE commands,
// drives the core register bus and the run-enable bits for capture and sequencer.
// Latency: reg_wr one cycle after the address byte; enables one cycle after the value byte.
// Backpressure: cmd_busy is high while a write waits for reg_ack; strobes then are dropped and set overrun.
//
// Ports:
//   clk, reset_n          core clock, synchronous active-low reset
//   cmd_in/cmd_wr         command byte and strobe (accepted when cmd_busy=0)
//   cmd_busy              write outstanding
//   reg_addr/reg_data     register write address/data, stable while reg_wr=1
//   reg_wr/reg_ack        write request held until acknowledged
//   capture_en, seq_en    run enables
//   err_opcode/length/timeout  registered single-cycle error pulses
//   overrun               sticky dropped-byte flag, cleared by CLRSTAT

module cmd_sequencer #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  cmd_in,
    input  logic        cmd_wr,
    output logic        cmd_busy,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_data,
    output logic        reg_wr,
    input  logic        reg_ack,
    output logic        capture_en,
    output logic        seq_en,
    output logic        err_opcode,
    output logic        err_length,
    output logic        err_timeout,
    output logic        overrun
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] OP_CTRL    = 8'h01;
    localparam logic [7:0] OP_CLRSTAT = 8'h02;
    localparam logic [7:0] OP_WRITE   = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CTRL_TGT,
        S_CTRL_VAL,
        S_WR_LEN,
        S_WR_DATA,
        S_WR_ADDR,
        S_WR_ISSUE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    tgt_q, tgt_d;
    logic [2:0]    len_q, len_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic [7:0]    addr_q, addr_d;
    logic          wr_q, wr_d;
    logic          cap_q, cap_d;
    logic          seq_q, seq_d;
    logic          eop_q, eop_d;
    logic          elen_q, elen_d;
    logic          eto_q, eto_d;
    logic          ovr_q, ovr_d;

    logic          accept;
    logic          in_frame;
    logic          tmo_hit;
    logic [TW-1:0] tmo_inc;
    logic [2:0]    cnt_inc;

    // cmd_busy is exactly the outstanding write request.
    assign accept   = cmd_wr && !wr_q;
    // States where the inter-byte timeout runs; IDLE and WR_ISSUE freeze it.
    assign in_frame = (state_q != S_IDLE) && (state_q != S_WR_ISSUE);
    assign tmo_inc  = tmo_q + TW'(1);
    // A byte on the expiring edge wins over the timeout.
    assign tmo_hit  = in_frame && !accept && (tmo_inc == TW'(TIMEOUT));
    assign cnt_inc  = cnt_q + 3'd1;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        tgt_d   = tgt_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        cap_d   = cap_q;
        seq_d   = seq_q;
        eop_d   = 1'b0;
        elen_d  = 1'b0;
        eto_d   = 1'b0;
        ovr_d   = ovr_q;

        // Dropped byte: flag it, leave framing state untouched.
        if (cmd_wr && wr_q) begin
            ovr_d = 1'b1;
        end

        if (in_frame) begin
            if (accept || tmo_hit) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_inc;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_in)
                        OP_CTRL:    state_d = S_CTRL_TGT;
                        OP_WRITE:   state_d = S_WR_LEN;
                        OP_CLRSTAT: ovr_d   = 1'b0;
                        default:    eop_d   = 1'b1;
                    endcase
                end
            end

            S_CTRL_TGT: begin
                if (accept) begin
                    tgt_d   = cmd_in[1:0];
                    state_d = S_CTRL_VAL;
                end
            end

            S_CTRL_VAL: begin
                if (accept) begin
                    // target 0 is a legal no-op.
                    if (tgt_q[0]) begin
                        cap_d = cmd_in[0];
                    end
                    if (tgt_q[1]) begin
                        seq_d = cmd_in[0];
                    end
                    state_d = S_IDLE;
                end
            end

            S_WR_LEN: begin
                if (accept) begin
                    if ((cmd_in >= 8'd1) && (cmd_in <= 8'd4)) begin
                        len_d   = cmd_in[2:0];
                        cnt_d   = 3'd0;
                        data_d  = 32'd0;
                        state_d = S_WR_DATA;
                    end else begin
                        elen_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_WR_DATA: begin
                if (accept) begin
                    // MSB-first shift; short writes leave upper bytes zero.
                    data_d = {data_q[23:0], cmd_in};
                    cnt_d  = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_WR_ADDR;
                    end
                end
            end

            S_WR_ADDR: begin
                if (accept) begin
                    addr_d  = cmd_in;
                    wr_d    = 1'b1;
                    state_d = S_WR_ISSUE;
                end
            end

            S_WR_ISSUE: begin
                // reg_wr is high throughout this state, so ack is only looked at here.
                if (reg_ack) begin
                    wr_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Abort a stalled frame; partial write data is discarded.
        if (tmo_hit) begin
            eto_d   = 1'b1;
            data_d  = 32'd0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            tgt_q   <= 2'd0;
            len_q   <= 3'd0;
            cnt_q   <= 3'd0;
            data_q  <= 32'd0;
            addr_q  <= 8'd0;
            wr_q    <= 1'b0;
            cap_q   <= 1'b0;
            seq_q   <= 1'b0;
            eop_q   <= 1'b0;
            elen_q  <= 1'b0;
            eto_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            tgt_q   <= tgt_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            cap_q   <= cap_d;
            seq_q   <= seq_d;
            eop_q   <= eop_d;
            elen_q  <= elen_d;
            eto_q   <= eto_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cmd_busy    = wr_q;
    assign reg_wr      = wr_q;
    assign reg_addr    = addr_q;
    assign reg_data    = data_q;
    assign capture_en  = cap_q;
    assign seq_en      = seq_q;
    assign err_opcode  = eop_q;
    assign err_length  = elen_q;
    assign err_timeout = eto_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Testbench for cmd_sequencer: directed scenarios plus randomized command streams
// compared against a frame-level reference model.
module tb_cmd_sequencer;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  cmd_in = 8'h00;
    logic        cmd_wr = 1'b0;
    logic        cmd_busy;
    logic [7:0]  reg_addr;
    logic [31:0] reg_data;
    logic        reg_wr;
    logic        reg_ack = 1'b0;
    logic        capture_en;
    logic        seq_en;
    logic        err_opcode;
    logic        err_length;
    logic        err_timeout;
    logic        overrun;

    int n_err = 0;
    int n_chk = 0;

    cmd_sequencer #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_in     (cmd_in),
        .cmd_wr     (cmd_wr),
        .cmd_busy   (cmd_busy),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .reg_wr     (reg_wr),
        .reg_ack    (reg_ack),
        .capture_en (capture_en),
        .seq_en     (seq_en),
        .err_opcode (err_opcode),
        .err_length (err_length),
        .err_timeout(err_timeout),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: collects the bytes of the current command and acts once
    // the command is complete, using the command grammar directly.
    logic [7:0]  fq[$];
    int          idle_cnt = 0;
    logic        m_busy = 1'b0, m_cap = 1'b0, m_seq = 1'b0, m_ovr = 1'b0;
    logic        m_eop = 1'b0, m_elen = 1'b0, m_eto = 1'b0;
    logic [7:0]  m_addr = 8'h00;
    logic [31:0] m_data = 32'h0;

    task automatic model_edge(input logic rn, input logic wr, input logic [7:0] b, input logic ack);
        m_eop = 1'b0; m_elen = 1'b0; m_eto = 1'b0;
        if (!rn) begin
            fq.delete(); idle_cnt = 0;
            m_busy = 1'b0; m_cap = 1'b0; m_seq = 1'b0; m_ovr = 1'b0;
        end else if (m_busy) begin
            if (wr) m_ovr = 1'b1;
            if (ack) m_busy = 1'b0;
        end else if (wr) begin
            fq.push_back(b);
            idle_cnt = 0;
            case (fq[0])
                8'h01: if (fq.size() == 3) begin
                    if (fq[1][0]) m_cap = fq[2][0];
                    if (fq[1][1]) m_seq = fq[2][0];
                    fq.delete();
                end
                8'h02: begin m_ovr = 1'b0; fq.delete(); end
                8'h05: if (fq.size() == 2 && (fq[1] == 8'd0 || fq[1] > 8'd4)) begin
                    m_elen = 1'b1; fq.delete();
                end else if (fq.size() >= 2 && fq.size() == int'(fq[1]) + 3) begin
                    m_data = 32'h0;
                    for (int i = 2; i < fq.size() - 1; i++) m_data = {m_data[23:0], fq[i]};
                    m_addr = fq[fq.size() - 1];
                    m_busy = 1'b1;
                    fq.delete();
                end
                default: begin m_eop = 1'b1; fq.delete(); end
            endcase
        end else if (fq.size() > 0) begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                m_eto = 1'b1; fq.delete(); idle_cnt = 0;
            end
        end
    endtask

    // One clock: inputs as set by the caller are taken at the edge, model follows,
    // outputs are then observed 1 time unit after the edge.
    task automatic tick();
        logic rn, wr, ak;
        logic [7:0] b;
        rn = reset_n; wr = cmd_wr; b = cmd_in; ak = reg_ack;
        @(posedge clk);
        model_edge(rn, wr, b, ak);
        #1;
    endtask

    logic [7:0] txq[$];

    task automatic send_txq();
        while (txq.size() > 0) begin
            cmd_wr = 1'b1;
            cmd_in = txq.pop_front();
            tick();
        end
        cmd_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        cmd_wr = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_wr = 1'b0; reg_ack = 1'b0;
        tick(); tick();
        n_chk++;
        if ({reg_wr, cmd_busy, reg_addr, reg_data, capture_en, seq_en, err_opcode, err_length, err_timeout, overrun} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got wr=%b busy=%b addr=%h data=%h cap=%b seq=%b errs=%b%b%b ovr=%b, want all 0",
                     reg_wr, cmd_busy, reg_addr, reg_data, capture_en, seq_en, err_opcode, err_length, err_timeout, overrun);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_ack_high();
        int wr_cycles = 0;
        logic any_err = 1'b0;
        reg_ack = 1'b1;
        txq = '{8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h40, 8'h02};
        send_txq();
        n_chk++;
        if (reg_wr !== 1'b1 || cmd_busy !== 1'b1 || reg_addr !== 8'h02 || reg_data !== 32'h00000040) begin
            n_err++;
            $display("FAIL write_ack_high_req: got wr=%b busy=%b addr=%h data=%h, want 1 1 02 00000040",
                     reg_wr, cmd_busy, reg_addr, reg_data);
        end
        for (int i = 0; i < 4; i++) begin
            if (reg_wr === 1'b1) wr_cycles++;
            any_err = any_err | err_opcode | err_length | err_timeout;
            tick();
        end
        n_chk++;
        if (wr_cycles != 1 || any_err !== 1'b0) begin
            n_err++;
            $display("FAIL write_ack_high_occupancy: got %0d reg_wr cycles err=%b, want 1 and 0", wr_cycles, any_err);
        end
    endtask

    task automatic test_ack_delayed();
        int wr_cycles = 0;
        reg_ack = 1'b0;
        txq = '{8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h40, 8'h02};
        send_txq();
        for (int i = 1; i <= 8; i++) begin
            if (reg_wr === 1'b1) wr_cycles++;
            if (i == 4) begin
                n_chk++;
                if (reg_addr !== 8'h02 || reg_data !== 32'h40 || cmd_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL ack_delayed_stable: got addr=%h data=%h busy=%b, want 02 00000040 1",
                             reg_addr, reg_data, cmd_busy);
                end
            end
            cmd_wr  = (i <= 3);
            cmd_in  = 8'h01;
            reg_ack = (i == 6);
            tick();
        end
        cmd_wr = 1'b0; reg_ack = 1'b0;
        n_chk++;
        if (wr_cycles != 6) begin
            n_err++;
            $display("FAIL ack_delayed_occupancy: got %0d cycles, want 6", wr_cycles);
        end
        n_chk++;
        if (overrun !== 1'b1 || capture_en !== 1'b0) begin
            n_err++;
            $display("FAIL ack_delayed_overrun: got ovr=%b cap=%b, want 1 0", overrun, capture_en);
        end
        txq = '{8'h02};
        send_txq();
        n_chk++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL clrstat: got ovr=%b, want 0", overrun);
        end
    endtask

    task automatic test_ctrl();
        txq = '{8'h01, 8'h01, 8'h01};
        send_txq();
        n_chk++;
        if ({capture_en, seq_en} !== 2'b10) begin
            n_err++;
            $display("FAIL ctrl_capture: got cap,seq=%b, want 10", {capture_en, seq_en});
        end
        txq = '{8'h01, 8'h02, 8'h01};
        send_txq();
        n_chk++;
        if ({capture_en, seq_en} !== 2'b11) begin
            n_err++;
            $display("FAIL ctrl_seq: got cap,seq=%b, want 11", {capture_en, seq_en});
        end
        txq = '{8'h01, 8'h03, 8'h00};
        send_txq();
        n_chk++;
        if ({capture_en, seq_en} !== 2'b00) begin
            n_err++;
            $display("FAIL ctrl_both_off: got cap,seq=%b, want 00", {capture_en, seq_en});
        end
        // target bits 7:2 ignored, target[1:0]=0 is a silent no-op
        txq = '{8'h01, 8'hFC, 8'h01};
        send_txq();
        n_chk++;
        if ({capture_en, seq_en, err_opcode, err_length, err_timeout} !== 5'b0) begin
            n_err++;
            $display("FAIL ctrl_noop: got cap,seq,errs=%b, want 00000",
                     {capture_en, seq_en, err_opcode, err_length, err_timeout});
        end
    endtask

    task automatic test_short_write_errors();
        reg_ack = 1'b1;
        txq = '{8'h05, 8'h02, 8'h12, 8'h34, 8'h07};
        send_txq();
        n_chk++;
        if (reg_wr !== 1'b1 || reg_addr !== 8'h07 || reg_data !== 32'h00001234) begin
            n_err++;
            $display("FAIL short_write: got wr=%b addr=%h data=%h, want 1 07 00001234", reg_wr, reg_addr, reg_data);
        end
        idle(1);
        txq = '{8'h05, 8'h00};
        send_txq();
        n_chk++;
        if (err_length !== 1'b1 || reg_wr !== 1'b0) begin
            n_err++;
            $display("FAIL len_zero: got elen=%b wr=%b, want 1 0", err_length, reg_wr);
        end
        txq = '{8'h05, 8'h07};
        send_txq();
        n_chk++;
        if (err_length !== 1'b1) begin
            n_err++;
            $display("FAIL len_over: got elen=%b, want 1", err_length);
        end
        idle(1);
        n_chk++;
        if (err_length !== 1'b0 || reg_wr !== 1'b0) begin
            n_err++;
            $display("FAIL len_pulse_width: got elen=%b wr=%b, want 0 0", err_length, reg_wr);
        end
        txq = '{8'h9A};
        send_txq();
        n_chk++;
        if (err_opcode !== 1'b1) begin
            n_err++;
            $display("FAIL bad_opcode: got eop=%b, want 1", err_opcode);
        end
        idle(1);
        n_chk++;
        if (err_opcode !== 1'b0) begin
            n_err++;
            $display("FAIL bad_opcode_width: got eop=%b, want 0", err_opcode);
        end
    endtask

    task automatic test_timeout();
        int first_to = -1;
        int to_seen = 0;
        reg_ack = 1'b1;
        txq = '{8'h05, 8'h04, 8'hAA};
        send_txq();
        for (int i = 1; i <= TMO + 2; i++) begin
            tick();
            if (err_timeout === 1'b1) begin
                to_seen++;
                if (first_to < 0) first_to = i;
            end
        end
        n_chk++;
        if (first_to != TMO || to_seen != 1) begin
            n_err++;
            $display("FAIL timeout_expire: got first at idle cycle %0d, %0d pulses, want %0d and 1", first_to, to_seen, TMO);
        end
        txq = '{8'h05, 8'h01, 8'hFF, 8'h03};
        send_txq();
        n_chk++;
        if (reg_wr !== 1'b1 || reg_addr !== 8'h03 || reg_data !== 32'h000000FF) begin
            n_err++;
            $display("FAIL after_timeout_write: got wr=%b addr=%h data=%h, want 1 03 000000FF", reg_wr, reg_addr, reg_data);
        end
        idle(1);
        // byte on the would-be expiring edge wins
        to_seen = 0;
        txq = '{8'h01};
        send_txq();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < TMO - 1; i++) begin
                tick();
                if (err_timeout === 1'b1) to_seen++;
            end
            txq = '{8'h01};
            send_txq();
            if (err_timeout === 1'b1) to_seen++;
        end
        n_chk++;
        if (to_seen != 0 || capture_en !== 1'b1) begin
            n_err++;
            $display("FAIL byte_wins_timeout: got %0d timeout pulses cap=%b, want 0 and 1", to_seen, capture_en);
        end
    endtask

    task automatic test_reset_mid_write();
        txq = '{8'h01, 8'h03, 8'h01};
        send_txq();
        reg_ack = 1'b0;
        txq = '{8'h05, 8'h01, 8'h5A, 8'h09};
        send_txq();
        idle(2);
        reset_n = 1'b0;
        tick();
        n_chk++;
        if ({reg_wr, cmd_busy, capture_en, seq_en, overrun} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_mid_write: got wr,busy,cap,seq,ovr=%b, want 00000",
                     {reg_wr, cmd_busy, capture_en, seq_en, overrun});
        end
        reset_n = 1'b1;
        reg_ack = 1'b1;
        txq = '{8'h05, 8'h01, 8'h5A, 8'h09};
        send_txq();
        n_chk++;
        if (reg_wr !== 1'b1 || reg_addr !== 8'h09 || reg_data !== 32'h0000005A) begin
            n_err++;
            $display("FAIL post_reset_write: got wr=%b addr=%h data=%h, want 1 09 0000005A", reg_wr, reg_addr, reg_data);
        end
        idle(1);
    endtask

    // One randomized cycle of the random scenario, compared against the model.
    task automatic random_step(input logic wr, input logic [7:0] b);
        cmd_wr  = wr;
        cmd_in  = b;
        reg_ack = ($urandom_range(0, 1) == 1);
        reset_n = ($urandom_range(0, 399) != 0);
        tick();
        reset_n = 1'b1;
        n_chk++;
        if ({reg_wr, cmd_busy, capture_en, seq_en, err_opcode, err_length, err_timeout, overrun} !==
            {m_busy, m_busy, m_cap, m_seq, m_eop, m_elen, m_eto, m_ovr}) begin
            n_err++;
            $display("FAIL random_ctrl @%0t: got wr,busy,cap,seq,eop,elen,eto,ovr=%b, want %b", $time,
                     {reg_wr, cmd_busy, capture_en, seq_en, err_opcode, err_length, err_timeout, overrun},
                     {m_busy, m_busy, m_cap, m_seq, m_eop, m_elen, m_eto, m_ovr});
        end
        if (m_busy) begin
            n_chk++;
            if (reg_addr !== m_addr || reg_data !== m_data) begin
                n_err++;
                $display("FAIL random_write @%0t: got addr=%h data=%h, want %h %h", $time, reg_addr, reg_data, m_addr, m_data);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] cq[$];
        for (int c = 0; c < 300; c++) begin
            int kind = $urandom_range(0, 9);
            int len;
            cq.delete();
            case (kind)
                0, 1, 2: begin
                    len = $urandom_range(1, 4);
                    cq.push_back(8'h05);
                    cq.push_back(8'(len));
                    for (int i = 0; i < len; i++) cq.push_back(8'($urandom));
                    cq.push_back(8'($urandom));
                end
                3, 4: begin
                    cq.push_back(8'h01);
                    cq.push_back(8'($urandom));
                    cq.push_back(8'($urandom));
                end
                5: cq.push_back(8'h02);
                6: cq.push_back(8'($urandom));
                7: begin
                    cq.push_back(8'h05);
                    cq.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(5, 255)));
                end
                8: begin
                    cq.push_back(8'h05);
                    cq.push_back(8'($urandom_range(1, 4)));
                    cq.push_back(8'($urandom));
                end
                default: for (int i = 0; i < 3; i++) cq.push_back(8'($urandom));
            endcase
            while (cq.size() > 0) begin
                int gap = $urandom_range(0, 2);
                if ($urandom_range(0, 19) == 0) gap = TMO - 1 + $urandom_range(0, 1);
                for (int g = 0; g < gap; g++) random_step(1'b0, 8'h00);
                random_step(1'b1, cq.pop_front());
            end
            for (int g = 0; g < $urandom_range(0, 3); g++) random_step(1'b0, 8'h00);
        end
        cmd_wr = 1'b0;
        reg_ack = 1'b1;
        idle(TMO + 2);
    endtask

    initial begin
        test_reset();
        test_write_ack_high();
        test_ack_delayed();
        test_ctrl();
        test_short_write_errors();
        test_timeout();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Byte-stream command sequencer between the FX2 command path and the timetag core. It frames incoming command bytes into opcodes and arguments, and issues 32-bit register writes to the core's register bus with a request/acknowledge handshake. It also owns the run-enable bits for the detector capture logic and the pulse sequencers. Bytes arrive already synchronized into the `clk` domain.

## Interface
- `TIMEOUT`, default 1024: idle cycles allowed between bytes of one command before the frame is aborted.
- `clk`  in  1  core clock; single clock domain.
- `reset_n`  in  1  reset, synchronous and active-low.
- `cmd_in`  in  8  command byte.
- `cmd_wr`  in  1  byte strobe; a byte is accepted on a rising edge with `cmd_wr=1 && cmd_busy=0`.
- `cmd_busy`  out  1  high while a register write is outstanding; bytes strobed then are dropped.
- `reg_addr`  out  8  register address, stable while `reg_wr=1`.
- `reg_data`  out  32  register write data, stable while `reg_wr=1`.
- `reg_wr`  out  1  write request, held until acknowledged.
- `reg_ack`  in  1  write acknowledge from the core.
- `capture_en`  out  1  detector capture enable.
- `seq_en`  out  1  pulse sequencer enable.
- `err_opcode`, `err_length`, `err_timeout`  out  1 each  single-cycle error pulses.
- `overrun`  out  1  sticky; set when a byte is dropped because `cmd_busy=1`.

## Operation
- Opcodes:
  - 0x01 CTRL: two argument bytes, `target` then `value`.
  - 0x02 CLRSTAT: no arguments; clears `overrun`.
  - 0x05 WRITE: `len`, then `len` data bytes MSB first, then `addr`.
  - Any other opcode: pulse `err_opcode` and stay in IDLE.
- States: IDLE, CTRL_TGT, CTRL_VAL, WR_LEN, WR_DATA, WR_ADDR, WR_ISSUE.
- IDLE: accepted byte is the opcode. 0x01 -> CTRL_TGT; 0x05 -> WR_LEN; 0x02 clears `overrun` and stays in IDLE.
- CTRL_TGT: latch `target[1:0]`; bits 7:2 are ignored. Go to CTRL_VAL.
- CTRL_VAL: `value[0]` is written to `capture_en` if `target[0]` is set, and to `seq_en` if `target[1]` is set. Go to IDLE. `target[1:0]=0` makes the command a no-op with no error.
- WR_LEN: `len` in 1..4 clears the data shift register and the byte counter, then goes to WR_DATA. `len` of 0 or >4 pulses `err_length` and returns to IDLE.
- WR_DATA: on each byte, `reg_data <= {reg_data[23:0], byte}` and the counter increments. After `len` bytes, go to WR_ADDR. Unused upper bytes stay zero.
- WR_ADDR: latch `reg_addr`, assert `reg_wr` and `cmd_busy`, go to WR_ISSUE.
- WR_ISSUE: hold until `reg_ack=1` is sampled, then return to IDLE.
- Timeout counter:
  - Counts cycles in CTRL_*, WR_LEN, WR_DATA and WR_ADDR; resets on every accepted byte.
  - Reaching `TIMEOUT` pulses `err_timeout` and returns to IDLE. Partial `reg_data` is discarded and no write is issued.
  - The counter is frozen in IDLE and WR_ISSUE.
- Dropped byte: a strobe during `cmd_busy=1` sets `overrun`. The state and data are unaffected.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. Asserting reset mid-frame or mid-write drops the frame or the pending write; `reg_wr` is low on the first edge with `reset_n=0`.
- `reg_wr`, `cmd_busy`, `reg_addr` and `reg_data` become valid one cycle after the edge that accepts the address byte.
- `reg_ack` is sampled only while `reg_wr=1`.
- `reg_wr` and `cmd_busy` deassert on the edge that samples `reg_ack=1`. The minimum write occupancy is 1 cycle, when ack is already high on the first request cycle.
- A new opcode can be accepted on the edge following the `reg_wr` deassertion.
- `capture_en`/`seq_en` update one cycle after the value byte is accepted.
- Error pulses are exactly 1 cycle wide and are registered.
- Byte accepted on the same edge the timeout would expire: the byte wins. The counter resets and no error is raised.
- Back-to-back bytes on every cycle are supported in all non-ISSUE states.

## Test plan
- Bytes 05 04 00 00 00 40 02, `reg_ack` tied high -> one `reg_wr` pulse with addr=0x02, data=0x00000040; no errors.
- Same write with `reg_ack` delayed 5 cycles; 3 bytes strobed during the wait -> `reg_wr` held for exactly 6 cycles, `overrun`=1, bytes ignored. A following 02 clears `overrun`.
- 01 01 01 then 01 02 01 then 01 03 00 -> `capture_en`=1, then `seq_en`=1, then both 0.
- 05 02 12 34 07 -> data=0x00001234, addr=0x07. 05 00 -> `err_length` pulse and no write. Opcode 0x9A -> `err_opcode` pulse.
- `TIMEOUT`=16; send 05 04 AA then idle 16 cycles -> `err_timeout` on the 16th cycle. A subsequent 05 01 FF 03 writes 0x000000FF to addr 0x03.
- `reset_n` low for one cycle during WR_ISSUE -> `reg_wr`, `cmd_busy` and enables go to 0; the next full command is decoded normally.
